// File: rtl/div_step_stage.sv
// One restoring-division step (trial subtract, quotient-bit insert, divisor shift) into a 1-entry output slot.
// Latency: 1 cycle from accept to valid_out; one operation per cycle when downstream is ready.
// Backpressure: ready_in = ~valid_out | ready_out; a full slot with ready_out low holds every output.
module div_step_stage #(
    parameter int divisorBITS  = 8,
    parameter int dividendBITS = 16,
    parameter int TAGBITS      = 4,
    localparam int addBITS     = divisorBITS + dividendBITS - 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [addBITS-1:0]      rem_in,
    input  logic [addBITS-1:0]      div_in,
    input  logic [dividendBITS-1:0] quo_in,
    input  logic                    dz_in,
    input  logic [TAGBITS-1:0]      tag_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [addBITS-1:0]      rem_out,
    output logic [addBITS-1:0]      div_out,
    output logic [dividendBITS-1:0] quo_out,
    output logic                    dz_out,
    output logic [TAGBITS-1:0]      tag_out
);

    logic [addBITS:0]        diff;
    logic                    borrow;
    logic                    accept;
    logic                    valid_d,  valid_q;
    logic [addBITS-1:0]      rem_d,    rem_q;
    logic [addBITS-1:0]      div_d,    div_q;
    logic [dividendBITS-1:0] quo_d,    quo_q;
    logic                    dz_q;
    logic [TAGBITS-1:0]      tag_q;

    // The extra top bit of the difference is the borrow: set when the divisor does not fit.
    always_comb begin
        diff   = {1'b0, rem_in} - {1'b0, div_in};
        borrow = diff[addBITS];
        rem_d  = borrow ? rem_in : diff[addBITS-1:0];
        div_d  = div_in >> 1;
        quo_d  = (quo_in << 1) | {{(dividendBITS-1){1'b0}}, ~borrow};
    end

    assign ready_in = ~valid_q | ready_out;
    assign accept   = valid_in & ready_in;
    assign valid_d  = accept | (valid_q & ~ready_out);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            dz_q    <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            // Data registers only move on accept so bubbles leave the slot contents untouched.
            if (accept) begin
                rem_q <= rem_d;
                div_q <= div_d;
                quo_q <= quo_d;
                dz_q  <= dz_in;
                tag_q <= tag_in;
            end
        end
    end

    assign valid_out = valid_q;
    assign rem_out   = rem_q;
    assign div_out   = div_q;
    assign quo_out   = quo_q;
    assign dz_out    = dz_q;
    assign tag_out   = tag_q;

endmodule

// File: tb/tb_div_step_stage.sv
// Bench for div_step_stage: a single stage for directed step/handshake/reset cases and a
// 16-stage chain forming the 16/8 divider for end-to-end division with random flow control.
module tb_div_step_stage;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- single stage ----------------
    logic        s_vi, s_ri, s_dz_i, s_vo, s_ro, s_dz_o;
    logic [22:0] s_rem_i, s_div_i, s_rem_o, s_div_o;
    logic [15:0] s_quo_i, s_quo_o;
    logic [3:0]  s_tag_i, s_tag_o;

    div_step_stage u_dut (
        .clock(clock), .reset_n(reset_n),
        .valid_in(s_vi), .ready_in(s_ri),
        .rem_in(s_rem_i), .div_in(s_div_i), .quo_in(s_quo_i), .dz_in(s_dz_i), .tag_in(s_tag_i),
        .valid_out(s_vo), .ready_out(s_ro),
        .rem_out(s_rem_o), .div_out(s_div_o), .quo_out(s_quo_o), .dz_out(s_dz_o), .tag_out(s_tag_o)
    );

    typedef struct {
        logic [22:0] rem;
        logic [22:0] dv;
        logic [15:0] quo;
        logic        dz;
        logic [3:0]  tag;
    } s_exp_t;

    s_exp_t s_q[$];

    function automatic s_exp_t model_step(input logic [22:0] rem, input logic [22:0] dv,
                                          input logic [15:0] quo, input logic dz,
                                          input logic [3:0] tag);
        s_exp_t e;
        logic   q;
        q     = (rem >= dv);
        e.rem = q ? rem - dv : rem;
        e.dv  = {1'b0, dv[22:1]};
        e.quo = {quo[14:0], q};
        e.dz  = dz;
        e.tag = tag;
        return e;
    endfunction

    task automatic send_s(input logic [22:0] rem, input logic [22:0] dv, input logic [15:0] quo,
                          input logic dz, input logic [3:0] tag, input s_exp_t e);
        int n;
        s_q.push_back(e);
        s_vi = 1'b1; s_rem_i = rem; s_div_i = dv; s_quo_i = quo; s_dz_i = dz; s_tag_i = tag;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!s_ri && n < 200);
        chk("s_hs_ready", s_ri, 1'b1);
        @(posedge clock);
        #1;
        s_vi = 1'b0; s_rem_i = 'x; s_div_i = 'x; s_quo_i = 'x;
    endtask

    always @(negedge clock) begin
        if (reset_n && s_vo && s_ro) begin
            if (s_q.size() == 0) begin
                chk("s_unexpected_out", 1'b1, 1'b0);
            end else begin
                s_exp_t e;
                e = s_q.pop_front();
                chk("s_rem", s_rem_o, e.rem);
                chk("s_div", s_div_o, e.dv);
                chk("s_quo", s_quo_o, e.quo);
                chk("s_dz",  s_dz_o,  e.dz);
                chk("s_tag", s_tag_o, e.tag);
            end
        end
    end

    // ---------------- 16-stage chain ----------------
    logic        c_vin, c_rout, c_dz_i;
    logic [22:0] c_rem_i, c_div_i;
    logic [15:0] c_quo_i;
    logic [3:0]  c_tag_i;

    logic        c_vld [0:16];
    logic        c_rdy [0:16];
    logic [22:0] c_rem [0:16];
    logic [22:0] c_div [0:16];
    logic [15:0] c_quo [0:16];
    logic        c_dz  [0:16];
    logic [3:0]  c_tag [0:16];

    assign c_vld[0]  = c_vin;
    assign c_rem[0]  = c_rem_i;
    assign c_div[0]  = c_div_i;
    assign c_quo[0]  = c_quo_i;
    assign c_dz[0]   = c_dz_i;
    assign c_tag[0]  = c_tag_i;
    assign c_rdy[16] = c_rout;

    for (genvar k = 0; k < 16; k++) begin : g_stage
        div_step_stage u_stage (
            .clock(clock), .reset_n(reset_n),
            .valid_in(c_vld[k]), .ready_in(c_rdy[k]),
            .rem_in(c_rem[k]), .div_in(c_div[k]), .quo_in(c_quo[k]), .dz_in(c_dz[k]), .tag_in(c_tag[k]),
            .valid_out(c_vld[k+1]), .ready_out(c_rdy[k+1]),
            .rem_out(c_rem[k+1]), .div_out(c_div[k+1]), .quo_out(c_quo[k+1]), .dz_out(c_dz[k+1]),
            .tag_out(c_tag[k+1])
        );
    end

    typedef struct {
        logic [15:0] quo;
        logic [22:0] rem;
        logic        dz;
        logic [3:0]  tag;
    } c_exp_t;

    c_exp_t c_q[$];
    time    t_acc;

    task automatic send_c(input logic [15:0] dividend, input logic [7:0] divisor, input logic [3:0] tag);
        c_exp_t e;
        int     n;
        e.dz  = (divisor == 8'd0);
        e.quo = e.dz ? 16'd0 : dividend / divisor;
        e.rem = e.dz ? 23'd0 : 23'(dividend % divisor);
        e.tag = tag;
        c_q.push_back(e);
        c_vin = 1'b1; c_rem_i = 23'(dividend); c_div_i = 23'(divisor) << 15;
        c_quo_i = 16'd0; c_dz_i = e.dz; c_tag_i = tag;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!c_rdy[0] && n < 200);
        chk("c_hs_ready", c_rdy[0], 1'b1);
        @(posedge clock);
        t_acc = $time;
        #1;
        c_vin = 1'b0;
    endtask

    always @(negedge clock) begin
        if (reset_n && c_vld[16] && c_rdy[16]) begin
            if (c_q.size() == 0) begin
                chk("c_unexpected_out", 1'b1, 1'b0);
            end else begin
                c_exp_t e;
                e = c_q.pop_front();
                chk("c_tag", c_tag[16], e.tag);
                chk("c_dz",  c_dz[16],  e.dz);
                if (!e.dz) begin
                    chk("c_quo", c_quo[16], e.quo);
                    chk("c_rem", c_rem[16], e.rem);
                end
            end
        end
    end

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((s_q.size() != 0 || c_q.size() != 0) && n < 300) begin
            @(posedge clock);
            n++;
        end
        #1;
        chk({tag, "_s_empty"}, s_q.size(), 0);
        chk({tag, "_c_empty"}, c_q.size(), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    bit   rand_done;
    time  t_first;

    initial begin
        reset_n = 1'b0;
        s_vi = 1'b0; s_ro = 1'b1; s_rem_i = '0; s_div_i = '0; s_quo_i = '0; s_dz_i = 1'b0; s_tag_i = '0;
        c_vin = 1'b0; c_rout = 1'b1; c_rem_i = '0; c_div_i = '0; c_quo_i = '0; c_dz_i = 1'b0; c_tag_i = '0;
        repeat (2) @(negedge clock);
        chk("rst_vo",  s_vo, 1'b0);
        chk("rst_rem", s_rem_o, 23'd0);
        chk("rst_div", s_div_o, 23'd0);
        chk("rst_quo", s_quo_o, 16'd0);
        chk("rst_dz",  s_dz_o, 1'b0);
        chk("rst_tag", s_tag_o, 4'd0);
        chk("rst_ready_in", s_ri, 1'b1);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Directed single steps with hand-derived results.
        send_s(23'd20,       23'd7,      16'h0005, 1'b0, 4'd1, '{23'd13,       23'd3,      16'h000B, 1'b0, 4'd1});
        send_s(23'd1000,     23'd229376, 16'h0000, 1'b0, 4'd2, '{23'd1000,     23'd114688, 16'h0000, 1'b0, 4'd2});
        send_s(23'd500,      23'd500,    16'h1234, 1'b0, 4'd3, '{23'd0,        23'd250,    16'h2469, 1'b0, 4'd3});
        send_s(23'd77,       23'd0,      16'h0000, 1'b0, 4'd4, '{23'd77,       23'd0,      16'h0001, 1'b0, 4'd4});
        send_s(23'h7FFFFF,   23'd1,      16'h8000, 1'b0, 4'd5, '{23'h7FFFFE,   23'd0,      16'h0001, 1'b0, 4'd5});
        send_s(23'd9,        23'd0,      16'h0000, 1'b1, 4'd6, '{23'd9,        23'd0,      16'h0001, 1'b1, 4'd6});
        send_s(23'd5,        23'd6,      16'hFFFF, 1'b0, 4'd7, '{23'd5,        23'd3,      16'hFFFE, 1'b0, 4'd7});
        drain("directed");

        // Stall: back-to-back ops, 3-cycle downstream stall with a full slot.
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    logic [22:0] r, d;
                    logic [15:0] q;
                    r = 23'(i * 37 + 5); d = 23'(i * 11 + 3); q = 16'(i * 4099);
                    send_s(r, d, q, 1'b0, 4'(i), model_step(r, d, q, 1'b0, 4'(i)));
                end
            end
            begin
                repeat (5) @(posedge clock);
                #1 s_ro = 1'b0;
                repeat (3) begin
                    @(negedge clock);
                    chk("stall_ready_in", s_ri, 1'b0);
                    chk("stall_vo", s_vo, 1'b1);
                    if (s_q.size() > 0) begin
                        chk("stall_rem", s_rem_o, s_q[0].rem);
                        chk("stall_quo", s_quo_o, s_q[0].quo);
                        chk("stall_tag", s_tag_o, s_q[0].tag);
                    end
                    @(posedge clock);
                end
                #1 s_ro = 1'b1;
            end
        join
        drain("stall");

        // Chain: directed divisions.
        send_c(16'd1000,  8'd7,   4'd1);
        send_c(16'd65535, 8'd255, 4'd2);
        send_c(16'd9,     8'd0,   4'd3);
        send_c(16'd0,     8'd1,   4'd4);
        send_c(16'd255,   8'd255, 4'd5);
        drain("chain_directed");

        // Chain throughput: downstream always ready, one accept per cycle.
        for (int i = 0; i < 64; i++) begin
            send_c(16'($urandom_range(0, 65535)), 8'($urandom_range(1, 255)), 4'(i));
            if (i == 0) t_first = t_acc;
        end
        chk("thru_cycles", 32'((t_acc - t_first) / 10), 32'd63);
        drain("thru");

        // Chain: random gaps and random downstream backpressure.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 3000; i++) begin
                    repeat ($urandom_range(0, 1)) begin
                        @(posedge clock);
                        #1;
                    end
                    send_c(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)), 4'(i));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clock);
                    #1 c_rout = ($urandom_range(0, 3) != 0);
                end
                c_rout = 1'b1;
            end
        join
        drain("random");

        // Async reset while a stalled result sits in the slot.
        s_ro = 1'b0;
        send_s(23'd300, 23'd100, 16'h0003, 1'b1, 4'd12, '{23'd200, 23'd50, 16'h0007, 1'b1, 4'd12});
        @(negedge clock);
        chk("pre_rst_vo", s_vo, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_vo",  s_vo, 1'b0);
        chk("mid_rst_rem", s_rem_o, 23'd0);
        chk("mid_rst_div", s_div_o, 23'd0);
        chk("mid_rst_quo", s_quo_o, 16'd0);
        chk("mid_rst_dz",  s_dz_o, 1'b0);
        chk("mid_rst_tag", s_tag_o, 4'd0);
        s_q.delete();
        c_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        s_ro = 1'b1;
        @(posedge clock);
        #1;
        send_s(23'd40, 23'd9, 16'h0001, 1'b0, 4'd9, '{23'd31, 23'd4, 16'h0003, 1'b0, 4'd9});
        send_c(16'd1000, 8'd7, 4'd10);
        drain("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
